border_broadcast: RTL and testbench

Per-router transmit side of the border-discovery exchange. While the router control state is BORDER (3'b100), the block floods this node's current bounding box (x_min, y_min, x_max, y_max) to every existing mesh neighbour. It re-broadcasts whenever a neighbour packet widens the box. Its packets are consumed by the neighbours' border receive logic, which treats any non-zero word as one valid packet.

---
 rtl/border_broadcast_pkg.sv | 54 +++++
 rtl/border_broadcast_if.sv | 20 ++
 rtl/border_broadcast_box_merge.sv | 25 ++
 rtl/border_broadcast.sv | 153 +++++++++++++++
 tb/tb_border_broadcast.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/border_broadcast_pkg.sv
// rtl/border_broadcast_pkg.sv - shared constants, types and packet packer for border_broadcast
package border_broadcast_pkg;

  localparam int T_D_WIDTH = 32;

  localparam logic [2:0] STATE_INIT   = 3'b000;
  localparam logic [2:0] STATE_BORDER = 3'b100;

  localparam int BRD_MARK    = 26;
  localparam int BRD_XMIN_HI = 25;
  localparam int BRD_XMIN_LO = 23;
  localparam int BRD_YMIN_HI = 22;
  localparam int BRD_YMIN_LO = 20;
  localparam int BRD_XMAX_HI = 19;
  localparam int BRD_XMAX_LO = 17;
  localparam int BRD_YMAX_HI = 16;
  localparam int BRD_YMAX_LO = 14;
  localparam int BRD_MYX_HI  = 13;
  localparam int BRD_MYX_LO  = 11;
  localparam int BRD_MYY_HI  = 10;
  localparam int BRD_MYY_LO  = 8;
  localparam int BRD_SEQ_HI  = 7;
  localparam int BRD_SEQ_LO  = 0;

  typedef enum logic [1:0] {
    FSM_IDLE,
    FSM_RUN,
    FSM_DONE
  } fsm_t;

  // Field order matches the packet so bits [25:14] map straight onto this struct.
  typedef struct packed {
    logic [2:0] x_min;
    logic [2:0] y_min;
    logic [2:0] x_max;
    logic [2:0] y_max;
  } box_t;

  function automatic logic [T_D_WIDTH-1:0] pack_border(input box_t box, input logic [2:0] my_x,
                                                       input logic [2:0] my_y, input logic [7:0] seq);
    logic [T_D_WIDTH-1:0] w;
    w = '0;
    w[BRD_MARK]                = 1'b1;
    w[BRD_XMIN_HI:BRD_XMIN_LO] = box.x_min;
    w[BRD_YMIN_HI:BRD_YMIN_LO] = box.y_min;
    w[BRD_XMAX_HI:BRD_XMAX_LO] = box.x_max;
    w[BRD_YMAX_HI:BRD_YMAX_LO] = box.y_max;
    w[BRD_MYX_HI:BRD_MYX_LO]   = my_x;
    w[BRD_MYY_HI:BRD_MYY_LO]   = my_y;
    w[BRD_SEQ_HI:BRD_SEQ_LO]   = seq;
    return w;
  endfunction

endpackage

// File: rtl/border_broadcast_if.sv
// rtl/border_broadcast_if.sv - four-way neighbour link bundle for border_broadcast
interface border_broadcast_if;
  import border_broadcast_pkg::*;

  logic [T_D_WIDTH-1:0] n_in, e_in, s_in, w_in;
  logic                 n_rdy, e_rdy, s_rdy, w_rdy;
  logic [T_D_WIDTH-1:0] n_out, e_out, s_out, w_out;

  modport master (
    input  n_in, e_in, s_in, w_in,
    input  n_rdy, e_rdy, s_rdy, w_rdy,
    output n_out, e_out, s_out, w_out
  );

  modport slave (
    output n_in, e_in, s_in, w_in,
    output n_rdy, e_rdy, s_rdy, w_rdy,
    input  n_out, e_out, s_out, w_out
  );
endinterface

// File: rtl/border_broadcast_box_merge.sv
// rtl/border_broadcast_box_merge.sv - box_merge: folds up to four neighbour boxes into the current box
module border_broadcast_box_merge
  import border_broadcast_pkg::*;
(
  input  box_t       cur,
  input  box_t       in_box [4],
  input  logic [3:0] in_valid,
  output box_t       merged,
  output logic       changed
);

  always_comb begin
    merged = cur;
    for (int p = 0; p < 4; p++) begin
      if (in_valid[p]) begin
        if (in_box[p].x_min < merged.x_min) merged.x_min = in_box[p].x_min;
        if (in_box[p].y_min < merged.y_min) merged.y_min = in_box[p].y_min;
        if (in_box[p].x_max > merged.x_max) merged.x_max = in_box[p].x_max;
        if (in_box[p].y_max > merged.y_max) merged.y_max = in_box[p].y_max;
      end
    end
    changed = (merged != cur);
  end

endmodule

// File: rtl/border_broadcast.sv
// rtl/border_broadcast.sv - floods the node bounding box to mesh neighbours during BORDER discovery
module border_broadcast
  import border_broadcast_pkg::*;
#(
  parameter int WIDTHX       = 6,
  parameter int WIDTHY       = 6,
  parameter int QUIET_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           state,
  input  logic [2:0]           my_x,
  input  logic [2:0]           my_y,
  border_broadcast_if.master   link,
  output logic [2:0]           x_min,
  output logic [2:0]           y_min,
  output logic [2:0]           x_max,
  output logic [2:0]           y_max,
  output logic [7:0]           seq,
  output logic                 busy,
  output logic                 done
);

  localparam logic [2:0] X_LAST     = 3'(WIDTHX - 1);
  localparam logic [2:0] Y_LAST     = 3'(WIDTHY - 1);
  localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYCLES - 1);

  // Port index order everywhere: 0=N, 1=E, 2=S, 3=W.
  logic [T_D_WIDTH-1:0] pkt_in [4];
  logic [T_D_WIDTH-1:0] out_q  [4];
  logic [T_D_WIDTH-1:0] out_d  [4];
  logic [3:0]           rdy, mask, in_valid, pending_q, pending_d;
  box_t                 in_box [4];
  box_t                 box_q, box_d, merged, own_box;
  logic                 changed, valid_any;
  fsm_t                 fsm_q, fsm_d;
  logic [7:0]           seq_q, seq_d, seq_inc, quiet_q, quiet_d;

  assign pkt_in[0] = link.n_in;
  assign pkt_in[1] = link.e_in;
  assign pkt_in[2] = link.s_in;
  assign pkt_in[3] = link.w_in;
  assign rdy       = {link.w_rdy, link.s_rdy, link.e_rdy, link.n_rdy};

  assign mask      = {my_x != 3'd0, my_y < Y_LAST, my_x < X_LAST, my_y != 3'd0};
  assign own_box   = {my_x, my_y, my_x, my_y};
  assign seq_inc   = (seq_q == 8'hFF) ? seq_q : seq_q + 8'd1;
  assign valid_any = |in_valid;

  // Any non-zero word counts as a packet, marker bit or not.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      in_valid[p] = mask[p] && (pkt_in[p] != '0);
      in_box[p]   = pkt_in[p][BRD_XMIN_HI:BRD_YMAX_LO];
    end
  end

  border_broadcast_box_merge u_box_merge (
    .cur      (box_q),
    .in_box   (in_box),
    .in_valid (in_valid),
    .merged   (merged),
    .changed  (changed)
  );

  always_comb begin
    fsm_d     = fsm_q;
    box_d     = box_q;
    seq_d     = seq_q;
    pending_d = pending_q;
    quiet_d   = quiet_q;
    for (int p = 0; p < 4; p++) out_d[p] = '0;

    if (state != STATE_BORDER) begin
      fsm_d     = FSM_IDLE;
      pending_d = '0;
      quiet_d   = '0;
      if (state == STATE_INIT) begin
        box_d = own_box;
        seq_d = '0;
      end
    end else begin
      case (fsm_q)
        FSM_IDLE: begin
          box_d     = own_box;
          pending_d = mask;
          seq_d     = '0;
          quiet_d   = '0;
          fsm_d     = FSM_RUN;
        end
        FSM_RUN: begin
          // Packets carry the pre-merge box; a same-cycle change re-arms every port below.
          for (int p = 0; p < 4; p++) begin
            if (pending_q[p] && rdy[p]) begin
              out_d[p]     = pack_border(box_q, my_x, my_y, seq_q);
              pending_d[p] = 1'b0;
            end
          end
          quiet_d = (valid_any || (pending_q != '0)) ? 8'd0 : quiet_q + 8'd1;
          if (changed) begin
            box_d     = merged;
            seq_d     = seq_inc;
            pending_d = mask;
          end else if (quiet_q == QUIET_LAST && pending_q == '0 && !valid_any) begin
            fsm_d = FSM_DONE;
          end
        end
        FSM_DONE: begin
          if (changed) begin
            box_d     = merged;
            seq_d     = seq_inc;
            pending_d = mask;
            quiet_d   = '0;
            fsm_d     = FSM_RUN;
          end
        end
        default: fsm_d = FSM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q     <= FSM_IDLE;
      box_q     <= '0;
      seq_q     <= '0;
      pending_q <= '0;
      quiet_q   <= '0;
      for (int p = 0; p < 4; p++) out_q[p] <= '0;
    end else begin
      fsm_q     <= fsm_d;
      box_q     <= box_d;
      seq_q     <= seq_d;
      pending_q <= pending_d;
      quiet_q   <= quiet_d;
      for (int p = 0; p < 4; p++) out_q[p] <= out_d[p];
    end
  end

  assign link.n_out = out_q[0];
  assign link.e_out = out_q[1];
  assign link.s_out = out_q[2];
  assign link.w_out = out_q[3];

  assign x_min = box_q.x_min;
  assign y_min = box_q.y_min;
  assign x_max = box_q.x_max;
  assign y_max = box_q.y_max;
  assign seq   = seq_q;
  assign busy  = (fsm_q == FSM_RUN);
  assign done  = (fsm_q == FSM_DONE);

endmodule

// File: tb/tb_border_broadcast.sv
// tb/tb_border_broadcast.sv - directed plus randomized bench for border_broadcast against a cycle model
module tb_border_broadcast;
  import border_broadcast_pkg::*;

  localparam int WX = 6;
  localparam int WY = 6;
  localparam int QC = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state, my_x, my_y;
  logic [2:0] x_min, y_min, x_max, y_max;
  logic [7:0] seq;
  logic       busy, done;

  logic [T_D_WIDTH-1:0] din  [4];
  logic [T_D_WIDTH-1:0] dout [4];
  logic [3:0]           rdy_v;

  border_broadcast_if link();

  assign link.n_in  = din[0];
  assign link.e_in  = din[1];
  assign link.s_in  = din[2];
  assign link.w_in  = din[3];
  assign link.n_rdy = rdy_v[0];
  assign link.e_rdy = rdy_v[1];
  assign link.s_rdy = rdy_v[2];
  assign link.w_rdy = rdy_v[3];
  assign dout[0]    = link.n_out;
  assign dout[1]    = link.e_out;
  assign dout[2]    = link.s_out;
  assign dout[3]    = link.w_out;

  border_broadcast #(.WIDTHX(WX), .WIDTHY(WY), .QUIET_CYCLES(QC)) dut (
    .clk   (clk),
    .reset (reset),
    .state (state),
    .my_x  (my_x),
    .my_y  (my_y),
    .link  (link),
    .x_min (x_min),
    .y_min (y_min),
    .x_max (x_max),
    .y_max (y_max),
    .seq   (seq),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 run, 2 done; box as {xmin, ymin, xmax, ymax}.
  int          m_mode;
  int          m_box [4];
  bit          m_pend [4];
  int          m_seq, m_quiet;
  logic [31:0] m_out [4];
  string       ptag [4] = '{"out_n", "out_e", "out_s", "out_w"};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit port_exists(input int p);
    case (p)
      0:       return my_y > 0;
      1:       return int'(my_x) < WX - 1;
      2:       return int'(my_y) < WY - 1;
      default: return my_x > 0;
    endcase
  endfunction

  function automatic logic [31:0] mk_pkt(input int a, input int b, input int c, input int d);
    return 32'((1 << 26) | (a << 23) | (b << 20) | (c << 17) | (d << 14));
  endfunction

  function automatic logic [31:0] exp_pkt(input int sq);
    return mk_pkt(m_box[0], m_box[1], m_box[2], m_box[3]) |
           32'((int'(my_x) << 11) | (int'(my_y) << 8) | sq);
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom & 32'h03FF_FFFF;
    if ($urandom_range(0, 3) != 0) w |= 32'h0400_0000;
    if ($urandom_range(0, 3) == 0) w |= ($urandom & 32'hF800_0000);
    if (w == 0) w = 32'h8000_0000;
    return w;
  endfunction

  function automatic void model_step();
    int  nb [4];
    bit  any_in, pend_any, widened;
    int  own [4];
    own = '{int'(my_x), int'(my_y), int'(my_x), int'(my_y)};
    for (int p = 0; p < 4; p++) m_out[p] = 0;
    if (reset) begin
      m_mode = 0; m_box = '{0, 0, 0, 0}; m_seq = 0; m_quiet = 0;
      for (int p = 0; p < 4; p++) m_pend[p] = 0;
      return;
    end
    if (state != 3'b100) begin
      m_mode = 0; m_quiet = 0;
      for (int p = 0; p < 4; p++) m_pend[p] = 0;
      if (state == 3'b000) begin m_box = own; m_seq = 0; end
      return;
    end
    if (m_mode == 0) begin
      m_box = own; m_seq = 0; m_quiet = 0; m_mode = 1;
      for (int p = 0; p < 4; p++) m_pend[p] = port_exists(p);
      return;
    end
    nb = m_box;
    any_in = 0;
    for (int p = 0; p < 4; p++) begin
      if (port_exists(p) && din[p] != 0) begin
        any_in = 1;
        nb[0] = (int'((din[p] >> 23) & 7) < nb[0]) ? int'((din[p] >> 23) & 7) : nb[0];
        nb[1] = (int'((din[p] >> 20) & 7) < nb[1]) ? int'((din[p] >> 20) & 7) : nb[1];
        nb[2] = (int'((din[p] >> 17) & 7) > nb[2]) ? int'((din[p] >> 17) & 7) : nb[2];
        nb[3] = (int'((din[p] >> 14) & 7) > nb[3]) ? int'((din[p] >> 14) & 7) : nb[3];
      end
    end
    widened = 0;
    for (int i = 0; i < 4; i++) if (nb[i] != m_box[i]) widened = 1;
    pend_any = 0;
    for (int p = 0; p < 4; p++) pend_any |= m_pend[p];
    if (m_mode == 1) begin
      for (int p = 0; p < 4; p++) begin
        if (m_pend[p] && rdy_v[p]) begin
          m_out[p] = exp_pkt(m_seq);
          m_pend[p] = 0;
        end
      end
    end
    if (widened) begin
      m_box = nb;
      m_seq = (m_seq < 255) ? m_seq + 1 : 255;
      m_quiet = 0;
      m_mode = 1;
      for (int p = 0; p < 4; p++) m_pend[p] = port_exists(p);
    end else if (m_mode == 1) begin
      if (!any_in && !pend_any && m_quiet == QC - 1) m_mode = 2;
      else m_quiet = (any_in || pend_any) ? 0 : m_quiet + 1;
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("x_min", 32'(x_min), 32'(m_box[0]));
    check("y_min", 32'(y_min), 32'(m_box[1]));
    check("x_max", 32'(x_max), 32'(m_box[2]));
    check("y_max", 32'(y_max), 32'(m_box[3]));
    check("seq", 32'(seq), 32'(m_seq));
    check("busy", 32'(busy), 32'(m_mode == 1));
    check("done", 32'(done), 32'(m_mode == 2));
    for (int p = 0; p < 4; p++) check(ptag[p], dout[p], m_out[p]);
  endtask

  task automatic clear_inputs();
    for (int p = 0; p < 4; p++) din[p] = '0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && !done; i++) tick();
    check("wait_done", 32'(done), 32'd1);
  endtask

  initial begin
    reset = 1'b1; state = 3'b000; my_x = 3'd0; my_y = 3'd0; rdy_v = 4'hF;
    clear_inputs();
    m_mode = 0; m_box = '{0, 0, 0, 0}; m_seq = 0; m_quiet = 0;
    for (int p = 0; p < 4; p++) begin m_pend[p] = 0; m_out[p] = 0; end
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_e_out", link.e_out, 32'd0);
    reset = 1'b0;

    // Corner node (0,0): only E and S exist.
    state = 3'b100;
    tick(); tick();
    check("corner_e", link.e_out, 32'h0400_0000);
    check("corner_s", link.s_out, 32'h0400_0000);
    check("corner_n", link.n_out, 32'd0);
    check("corner_w", link.w_out, 32'd0);
    for (int i = 1; i <= QC; i++) begin
      tick();
      check("corner_done", 32'(done), 32'(i == QC));
    end

    // Box widening at (2,2) from the east.
    state = 3'b000; tick();
    my_x = 3'd2; my_y = 3'd2; state = 3'b100;
    repeat (4) tick();
    din[1] = mk_pkt(3, 1, 5, 4);
    tick();
    clear_inputs();
    check("widen_box", {20'd0, x_min, y_min, x_max, y_max}, {20'd0, 3'd2, 3'd1, 3'd5, 3'd4});
    check("widen_seq", 32'(seq), 32'd1);
    tick();
    check("widen_n", link.n_out, 32'h051B_1201);
    check("widen_e", link.e_out, 32'h051B_1201);
    check("widen_s", link.s_out, 32'h051B_1201);
    check("widen_w", link.w_out, 32'h051B_1201);

    // Two inputs in one cycle merge once.
    state = 3'b000; tick();
    state = 3'b100;
    repeat (4) tick();
    din[0] = mk_pkt(1, 0, 2, 2);
    din[3] = mk_pkt(0, 2, 2, 5);
    tick();
    clear_inputs();
    check("simul_box", {20'd0, x_min, y_min, x_max, y_max}, {20'd0, 3'd0, 3'd0, 3'd2, 3'd5});
    check("simul_seq", 32'(seq), 32'd1);
    repeat (2) tick();

    // South backpressure for ten cycles.
    state = 3'b000; tick();
    rdy_v[2] = 1'b0; state = 3'b100;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_s_idle", link.s_out, 32'd0);
      check("bp_no_done", 32'(done), 32'd0);
    end
    rdy_v[2] = 1'b1;
    tick();
    check("bp_s_pkt", link.s_out, 32'h0524_9200);
    tick();
    check("bp_s_once", link.s_out, 32'd0);

    // DONE re-entry on widening, stay in DONE otherwise.
    wait_done(40);
    din[1] = mk_pkt(2, 2, 4, 2);
    tick();
    clear_inputs();
    check("reenter_busy", 32'(busy), 32'd1);
    tick();
    check("reenter_e", link.e_out, 32'h0528_9201);
    wait_done(40);
    din[1] = mk_pkt(2, 2, 3, 2);
    tick();
    clear_inputs();
    check("nowiden_done", 32'(done), 32'd1);
    check("nowiden_busy", 32'(busy), 32'd0);

    // Reset mid-RUN.
    din[0] = mk_pkt(0, 0, 5, 5);
    tick();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_box", {20'd0, x_min, y_min, x_max, y_max}, 32'd0);
    check("midrst_seq", 32'(seq), 32'd0);
    check("midrst_n", link.n_out, 32'd0);

    // INIT reloads own box and clears seq.
    repeat (3) tick();
    din[1] = mk_pkt(0, 0, 5, 5);
    tick();
    clear_inputs();
    state = 3'b000;
    tick();
    check("init_box", {20'd0, x_min, y_min, x_max, y_max}, {20'd0, 3'd2, 3'd2, 3'd2, 3'd2});
    check("init_seq", 32'(seq), 32'd0);
    check("init_e", link.e_out, 32'd0);

    // Randomized traffic, backpressure, state changes and occasional reset.
    for (int c = 0; c < 2500; c++) begin
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 59) == 0) begin
        state = 3'($urandom_range(0, 7));
        if (state != 3'b100) begin
          my_x = 3'($urandom_range(0, WX - 1));
          my_y = 3'($urandom_range(0, WY - 1));
        end
      end else if (state != 3'b100 && $urandom_range(0, 3) == 0) begin
        state = 3'b100;
      end
      for (int p = 0; p < 4; p++) begin
        din[p]   = ($urandom_range(0, 7) == 0) ? rnd_word() : '0;
        rdy_v[p] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
